input_debounce: RTL and testbench

- Synchronises and debounces WIDTH asynchronous board inputs (slide switches, push-buttons) before they reach the system's button PIO input.
- Produces a clean, stable level for each bit, plus one-cycle press (rise) and release (fall) pulses.
- Sits between the board input pins and the system PIO, in the 50 MHz system clock domain.

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_bit.sv | 51 +++++
 rtl/input_debounce.sv | 51 +++++
 tb/tb_input_debounce.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the input debouncer.
package debounce_pkg;

  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_DEBOUNCE_COUNT = 500000;

  function automatic int cnt_width(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser, hold counter, stable level and press/release pulses.
// Latency SYNC_STAGES+DEBOUNCE_COUNT cycles from a stable din; free-running, no backpressure.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
  input  logic clk,
  input  logic rstN,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;
      // Any cycle agreeing with the current level restarts the hold window.
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        dout <= s;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Debounces WIDTH board inputs into levels plus rise/fall pulses; latency SYNC_STAGES+DEBOUNCE_COUNT, no backpressure.
// Define INPUT_DEBOUNCE_CAPTURE_EN to add a sticky rise-capture register (W1C) and an irq output.
module input_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`ifdef INPUT_DEBOUNCE_CAPTURE_EN
  ,
  input  logic [WIDTH-1:0] capture_clr,
  output logic [WIDTH-1:0] capture,
  output logic             irq
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
    ) u_bit (
      .clk  (clk),
      .rstN (rstN),
      .din  (din[i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

`ifdef INPUT_DEBOUNCE_CAPTURE_EN
  // Set has priority so a press landing on a clear strobe is not lost.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      capture <= '0;
    end else begin
      capture <= (capture & ~capture_clr) | rise;
    end
  end

  assign irq = |capture;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed, table-driven bench for input_debounce with WIDTH=8, SYNC_STAGES=2, DEBOUNCE_COUNT=4.
module tb_input_debounce;

  logic       clk;
  logic       rstN;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] rise;
  logic [7:0] fall;
`ifdef INPUT_DEBOUNCE_CAPTURE_EN
  logic [7:0] capture_clr;
  logic [7:0] capture;
  logic       irq;
`endif

  int tests;
  int failed;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t vecs[$];

  input_debounce #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_COUNT (4)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
`ifdef INPUT_DEBOUNCE_CAPTURE_EN
    ,
    .capture_clr (capture_clr),
    .capture     (capture),
    .irq         (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic [7:0] o, input logic [7:0] r, input logic [7:0] f);
    vec_t v;
    v.din  = d;
    v.dout = o;
    v.rise = r;
    v.fall = f;
    vecs.push_back(v);
  endtask

  task automatic add_n(input logic [7:0] d, input logic [7:0] o, input int n);
    for (int k = 0; k < n; k++) add(d, o, 8'h00, 8'h00);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rstN   = 1'b0;
    din    = 8'h00;
`ifdef INPUT_DEBOUNCE_CAPTURE_EN
    capture_clr = 8'h00;
`endif

    // Vector k is driven just after edge k; its expectation is sampled after edge k+1.
    // Single bit press: level and pulse at edge 6 only.
    add_n(8'h01, 8'h00, 5);
    add(8'h01, 8'h01, 8'h01, 8'h00);
    add(8'h01, 8'h01, 8'h00, 8'h00);
    // All bits high; bit 0 already set so only FE pulses.
    add_n(8'hFF, 8'h01, 5);
    add(8'hFF, 8'hFF, 8'hFE, 8'h00);
    add(8'hFF, 8'hFF, 8'h00, 8'h00);
    // Multi-bit release.
    add_n(8'h5A, 8'hFF, 5);
    add(8'h5A, 8'h5A, 8'h00, 8'hA5);
    add(8'h5A, 8'h5A, 8'h00, 8'h00);
    // Bit 0 bounce: high 3, low 1, then steady from edge 4; accepted at edge 10.
    add_n(8'h5B, 8'h5A, 3);
    add(8'h5A, 8'h5A, 8'h00, 8'h00);
    add_n(8'h5B, 8'h5A, 5);
    add(8'h5B, 8'h5B, 8'h01, 8'h00);
    add(8'h5B, 8'h5B, 8'h00, 8'h00);

    repeat (3) step();
    check("reset_state", {8'h0, dout, rise, fall}, 32'h0);
    rstN = 1'b1;
    repeat (2) step();
    check("idle_after_reset", {8'h0, dout, rise, fall}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      din = vecs[i].din;
      step();
      check($sformatf("vec%0d", i), {8'h0, dout, rise, fall},
            {8'h0, vecs[i].dout, vecs[i].rise, vecs[i].fall});
    end

    // Reset in the middle of a count.
    din = 8'h80;
    repeat (4) step();
    check("midcount_pre", {8'h0, dout, rise, fall}, {8'h0, 8'h5B, 8'h00, 8'h00});
    rstN = 1'b0;
    #1;
    check("midcount_rst", {8'h0, dout, rise, fall}, 32'h0);
    repeat (2) step();
    rstN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("post_rst_e%0d", e), {8'h0, dout, rise, fall},
            {8'h0, (e >= 6) ? 8'h80 : 8'h00, (e == 6) ? 8'h80 : 8'h00, 8'h00});
    end

    // Input already high when reset releases: one press pulse, then quiet.
    rstN = 1'b0;
    din  = 8'h03;
    repeat (2) step();
    rstN = 1'b1;
    for (int e = 1; e <= 106; e++) begin
      step();
      check($sformatf("rel_high_e%0d", e), {8'h0, dout, rise, fall},
            {8'h0, (e >= 6) ? 8'h03 : 8'h00, (e == 6) ? 8'h03 : 8'h00, 8'h00});
    end

`ifdef INPUT_DEBOUNCE_CAPTURE_EN
    capture_clr = 8'hFF;
    step();
    capture_clr = 8'h00;
    check("cap_cleared", {23'h0, irq, capture}, 32'h0);
    din = 8'h07;
    repeat (6) step();
    check("cap_rise2", {24'h0, rise}, 32'h04);
    step();
    check("cap_set", {23'h0, irq, capture}, {23'h0, 1'b1, 8'h04});
    din = 8'h03;
    repeat (7) step();
    check("cap_fall2", {8'h0, dout, rise, fall}, {8'h0, 8'h03, 8'h00, 8'h00});
    din = 8'h07;
    repeat (6) step();
    check("cap_rise2_again", {24'h0, rise}, 32'h04);
    capture_clr = 8'h04;
    step();
    capture_clr = 8'h00;
    check("cap_set_wins", {23'h0, irq, capture}, {23'h0, 1'b1, 8'h04});
    capture_clr = 8'h04;
    step();
    capture_clr = 8'h00;
    check("cap_clr", {23'h0, irq, capture}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
